// File: rtl/lc_pkg.sv
// Shared lifecycle definitions used by the transition arbiter and by
// lifecycle_protection.
//   ID_W        : default authentication identifier width
//   LC_EOL      : end-of-life lifecycle state encoding; no transitions allowed
//   arb_state_t : transition arbiter FSM states
package lc_pkg;

    localparam int ID_W = 256;

    localparam logic [2:0] LC_EOL = 3'd5;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RELEASE,
        DONE
    } arb_state_t;

endpackage

// File: rtl/lc_rr_arbiter.sv
// Combinational round-robin pick. The search starts at ptr and wraps modulo
// NUM_REQ; the first eligible index wins. The pointer register lives in the
// parent.
//   eligible : requesters allowed to be granted this cycle
//   ptr      : index where the search starts (must be < NUM_REQ)
//   grant    : one-hot grant (all zero when nothing is eligible)
//   idx      : binary index of the granted requester
//   any      : at least one requester is eligible
module lc_rr_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] eligible,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    always_comb begin
        int j;
        j     = 0;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            j = int'(ptr) + i;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (!any && eligible[j]) begin
                any      = 1'b1;
                grant[j] = 1'b1;
                idx      = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/lc_transition_arbiter.sv
// Shares the single lifecycle transition port among NUM_REQ requesters.
// One authentication attempt runs at a time; lc_success_i passes it, a
// response timeout fails it. Consecutive failures per requester are counted
// and a requester is locked out (until reset) once MAX_FAILS is reached.
//   clk, rst     : clock, asynchronous active-low reset
//   req          : per-requester request level, held until its done
//   req_id       : identifier of requester i in [i*ID_W +: ID_W]
//   done, ok     : one-cycle completion pulse and result per requester
//   locked       : sticky per-requester lockout
//   busy         : attempt in flight
//   lc_req_o     : transition request to lifecycle_protection
//   lc_id_o      : identifier to lifecycle_protection
//   lc_success_i : success level from lifecycle_protection
//   lc_state_i   : current lifecycle state
//
// state   | meaning
// IDLE    | pick next eligible requester (round robin)
// WAIT    | lc_req_o high, waiting for success or timeout
// RELEASE | lc_req_o low for RELEASE_CYC cycles so protection can rearm
// DONE    | report result, update fail counter / lockout
module lc_transition_arbiter
    import lc_pkg::*;
#(
    parameter int NUM_REQ     = 3,
    parameter int ID_W        = lc_pkg::ID_W,
    parameter int TIMEOUT     = 16,
    parameter int MAX_FAILS   = 3,
    parameter int RELEASE_CYC = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [NUM_REQ*ID_W-1:0] req_id,
    output logic [NUM_REQ-1:0]      done,
    output logic [NUM_REQ-1:0]      ok,
    output logic [NUM_REQ-1:0]      locked,
    output logic                    busy,
    output logic                    lc_req_o,
    output logic [ID_W-1:0]         lc_id_o,
    input  logic                    lc_success_i,
    input  logic [2:0]              lc_state_i
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int TMR_W = $clog2(TIMEOUT + RELEASE_CYC);
    localparam int CNT_W = $clog2(MAX_FAILS + 1);

    arb_state_t state, next_state;

    logic [NUM_REQ-1:0] gnt_oh, sel_oh;
    logic [PTR_W-1:0]   gnt_idx, sel_idx, rr_ptr;
    logic               gnt_any;
    logic [TMR_W-1:0]   timer;
    logic               result;
    logic               eol_skip;
    logic [CNT_W-1:0]   fail_cnt [NUM_REQ];

    logic [NUM_REQ-1:0] done_d, ok_d;
    logic               lc_req_d, busy_d;
    logic               wait_exit, rel_exit;

    lc_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (PTR_W)
    ) u_rr (
        .eligible (req & ~locked),
        .ptr      (rr_ptr),
        .grant    (gnt_oh),
        .idx      (gnt_idx),
        .any      (gnt_any)
    );

    assign wait_exit = lc_success_i || (timer == TMR_W'(TIMEOUT - 1));
    assign rel_exit  = (timer == TMR_W'(RELEASE_CYC - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (gnt_any) next_state = (lc_state_i == LC_EOL) ? DONE : WAIT;
            WAIT:    if (wait_exit) next_state = RELEASE;
            RELEASE: if (rel_exit) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Next values of the registered outputs.
    always_comb begin
        lc_req_d = (next_state == WAIT);
        busy_d   = (next_state != IDLE);
        done_d   = (state == DONE) ? sel_oh : '0;
        ok_d     = (state == DONE && result) ? sel_oh : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done     <= '0;
            ok       <= '0;
            locked   <= '0;
            busy     <= 1'b0;
            lc_req_o <= 1'b0;
            lc_id_o  <= '0;
            rr_ptr   <= '0;
            sel_oh   <= '0;
            sel_idx  <= '0;
            timer    <= '0;
            result   <= 1'b0;
            eol_skip <= 1'b0;
            for (int i = 0; i < NUM_REQ; i++) fail_cnt[i] <= '0;
        end else begin
            done     <= done_d;
            ok       <= ok_d;
            busy     <= busy_d;
            lc_req_o <= lc_req_d;

            // Timer restarts on every state change so WAIT and RELEASE share it.
            if (state != next_state) timer <= '0;
            else                     timer <= timer + 1'b1;

            case (state)
                IDLE: begin
                    if (gnt_any) begin
                        sel_oh   <= gnt_oh;
                        sel_idx  <= gnt_idx;
                        result   <= 1'b0;
                        eol_skip <= (lc_state_i == LC_EOL);
                        rr_ptr   <= (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
                        if (lc_state_i != LC_EOL) lc_id_o <= req_id[gnt_idx*ID_W +: ID_W];
                    end
                end
                WAIT: begin
                    // Success wins over a simultaneous timeout.
                    if (wait_exit) begin
                        result  <= lc_success_i;
                        lc_id_o <= '0;
                    end
                end
                DONE: begin
                    // An EOL refusal is not an authentication failure.
                    if (!eol_skip) begin
                        if (result) begin
                            fail_cnt[sel_idx] <= '0;
                        end else begin
                            if (fail_cnt[sel_idx] != CNT_W'(MAX_FAILS))
                                fail_cnt[sel_idx] <= fail_cnt[sel_idx] + 1'b1;
                            if (fail_cnt[sel_idx] >= CNT_W'(MAX_FAILS - 1))
                                locked[sel_idx] <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lc_transition_arbiter.sv
module tb_lc_transition_arbiter;

    localparam int NUM_REQ = 3;
    localparam int ID_W    = 256;

    logic                    clk = 1'b0;
    logic                    rst = 1'b0;
    logic [NUM_REQ-1:0]      req = '0;
    logic [NUM_REQ*ID_W-1:0] req_id = '0;
    logic [NUM_REQ-1:0]      done, ok, locked;
    logic                    busy, lc_req_o;
    logic [ID_W-1:0]         lc_id_o;
    logic                    lc_success_i = 1'b0;
    logic [2:0]              lc_state_i = 3'd2;

    int checks   = 0;
    int failures = 0;

    logic [ID_W-1:0] id0, id1, id2;

    lc_transition_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .ID_W        (ID_W),
        .TIMEOUT     (16),
        .MAX_FAILS   (3),
        .RELEASE_CYC (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .req_id       (req_id),
        .done         (done),
        .ok           (ok),
        .locked       (locked),
        .busy         (busy),
        .lc_req_o     (lc_req_o),
        .lc_id_o      (lc_id_o),
        .lc_success_i (lc_success_i),
        .lc_state_i   (lc_state_i)
    );

    always #5 clk = ~clk;

    // Drives one attempt starting in IDLE cycle 0 (caller sits #1 after an edge)
    // and returns observations. succ_at: cycle in which lc_success_i is high
    // (-1 = never). keep: leave req asserted after done.
    task automatic run_attempt(input logic [2:0] r, input int succ_at, input bit keep,
                               output int done_cyc, output logic [2:0] done_v,
                               output logic [2:0] ok_v, output int req_hi,
                               output logic [ID_W-1:0] id_at1);
        req      = r;
        done_cyc = -1;
        done_v   = '0;
        ok_v     = '0;
        req_hi   = 0;
        id_at1   = '0;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk); #1;
            lc_success_i = (c == succ_at);
            if (lc_req_o) req_hi++;
            if (c == 1) id_at1 = lc_id_o;
            if (done != '0) begin
                done_cyc     = c;
                done_v       = done;
                ok_v         = ok;
                lc_success_i = 1'b0;
                if (!keep) req = '0;
                break;
            end
        end
        lc_success_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (done !== 3'b000)   begin failures++; $display("FAIL reset_done got=%b exp=000", done); end
        checks++; if (ok !== 3'b000)     begin failures++; $display("FAIL reset_ok got=%b exp=000", ok); end
        checks++; if (locked !== 3'b000) begin failures++; $display("FAIL reset_locked got=%b exp=000", locked); end
        checks++; if (busy !== 1'b0)     begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (lc_req_o !== 1'b0) begin failures++; $display("FAIL reset_lc_req got=%b exp=0", lc_req_o); end
        checks++; if (lc_id_o !== '0)    begin failures++; $display("FAIL reset_lc_id got=%h exp=0", lc_id_o); end
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_round_robin();
        int dc, rh;
        logic [2:0] dv, ov, exp_oh;
        logic [ID_W-1:0] ida;
        logic [2:0] order [4];
        order[0] = 3'b001; order[1] = 3'b010; order[2] = 3'b100; order[3] = 3'b001;
        for (int k = 0; k < 4; k++) begin
            exp_oh = order[k];
            run_attempt(3'b111, 4, 1'b1, dc, dv, ov, rh, ida);
            checks++; if (dv !== exp_oh) begin failures++; $display("FAIL rr_done[%0d] got=%b exp=%b", k, dv, exp_oh); end
            checks++; if (ov !== exp_oh) begin failures++; $display("FAIL rr_ok[%0d] got=%b exp=%b", k, ov, exp_oh); end
        end
        req = '0;
        @(posedge clk); #1;
    endtask

    task automatic test_pass();
        int dc, rh;
        logic [2:0] dv, ov;
        logic [ID_W-1:0] ida;
        run_attempt(3'b001, 4, 1'b0, dc, dv, ov, rh, ida);
        checks++; if (dc !== 8)       begin failures++; $display("FAIL pass_done_cycle got=%0d exp=8", dc); end
        checks++; if (dv !== 3'b001)  begin failures++; $display("FAIL pass_done got=%b exp=001", dv); end
        checks++; if (ov !== 3'b001)  begin failures++; $display("FAIL pass_ok got=%b exp=001", ov); end
        checks++; if (rh !== 4)       begin failures++; $display("FAIL pass_req_cycles got=%0d exp=4", rh); end
        checks++; if (ida !== id0)    begin failures++; $display("FAIL pass_id got=%h exp=%h", ida, id0); end
        checks++; if (lc_id_o !== '0) begin failures++; $display("FAIL pass_id_cleared got=%h exp=0", lc_id_o); end
    endtask

    task automatic test_fail_lockout();
        int dc, rh;
        logic [2:0] dv, ov, exp_lock;
        logic [ID_W-1:0] ida;
        for (int k = 0; k < 3; k++) begin
            run_attempt(3'b010, -1, 1'b0, dc, dv, ov, rh, ida);
            exp_lock = (k == 2) ? 3'b010 : 3'b000;
            checks++; if (rh !== 16)          begin failures++; $display("FAIL fail_req_cycles[%0d] got=%0d exp=16", k, rh); end
            checks++; if (dc !== 20)          begin failures++; $display("FAIL fail_done_cycle[%0d] got=%0d exp=20", k, dc); end
            checks++; if (dv !== 3'b010 || ov !== 3'b000)
                begin failures++; $display("FAIL fail_done_ok[%0d] got=%b/%b exp=010/000", k, dv, ov); end
            checks++; if (locked !== exp_lock) begin failures++; $display("FAIL fail_locked[%0d] got=%b exp=%b", k, locked, exp_lock); end
        end
        checks++; if (ida !== id1) begin failures++; $display("FAIL fail_id got=%h exp=%h", ida, id1); end
    endtask

    task automatic test_locked_ignored();
        int hi_cnt, done_cnt, dc, rh;
        logic [2:0] dv, ov;
        logic [ID_W-1:0] ida;
        hi_cnt = 0; done_cnt = 0;
        req = 3'b010;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk); #1;
            if (lc_req_o) hi_cnt++;
            if (done != '0) done_cnt++;
        end
        req = '0;
        checks++; if (hi_cnt !== 0)   begin failures++; $display("FAIL locked_lc_req got=%0d exp=0", hi_cnt); end
        checks++; if (done_cnt !== 0) begin failures++; $display("FAIL locked_done got=%0d exp=0", done_cnt); end
        run_attempt(3'b011, 4, 1'b0, dc, dv, ov, rh, ida);
        checks++; if (dv !== 3'b001 || ov !== 3'b001)
            begin failures++; $display("FAIL locked_grant0 got=%b/%b exp=001/001", dv, ov); end
    endtask

    task automatic test_eol();
        int dc, rh;
        logic [2:0] dv, ov;
        logic [ID_W-1:0] ida;
        // Two real failures on requester 2 first: count = 2.
        for (int k = 0; k < 2; k++) begin
            run_attempt(3'b100, -1, 1'b0, dc, dv, ov, rh, ida);
            checks++; if (dv !== 3'b100 || ov !== 3'b000)
                begin failures++; $display("FAIL eol_prefail[%0d] got=%b/%b exp=100/000", k, dv, ov); end
        end
        lc_state_i = 3'd5;
        run_attempt(3'b100, 2, 1'b0, dc, dv, ov, rh, ida);
        checks++; if (dc !== 2)         begin failures++; $display("FAIL eol_done_cycle got=%0d exp=2", dc); end
        checks++; if (dv !== 3'b100)    begin failures++; $display("FAIL eol_done got=%b exp=100", dv); end
        checks++; if (ov !== 3'b000)    begin failures++; $display("FAIL eol_ok got=%b exp=000", ov); end
        checks++; if (rh !== 0)         begin failures++; $display("FAIL eol_lc_req got=%0d exp=0", rh); end
        checks++; if (locked !== 3'b010) begin failures++; $display("FAIL eol_counter_unchanged got=%b exp=010", locked); end
        lc_state_i = 3'd2;
        // Third real failure locks only if EOL left the count at 2.
        run_attempt(3'b100, -1, 1'b0, dc, dv, ov, rh, ida);
        checks++; if (locked !== 3'b110) begin failures++; $display("FAIL eol_then_lock got=%b exp=110", locked); end
    endtask

    task automatic test_reset_mid();
        int dc, rh;
        logic [2:0] dv, ov;
        logic [ID_W-1:0] ida;
        req = 3'b001;
        repeat (5) @(posedge clk);
        #1;
        checks++; if (lc_req_o !== 1'b1) begin failures++; $display("FAIL mid_wait_lc_req got=%b exp=1", lc_req_o); end
        rst = 1'b0;
        #1;
        checks++; if (lc_req_o !== 1'b0) begin failures++; $display("FAIL mid_async_lc_req got=%b exp=0", lc_req_o); end
        req = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (locked !== 3'b000) begin failures++; $display("FAIL mid_locked got=%b exp=000", locked); end
        checks++; if (busy !== 1'b0 || done !== 3'b000 || ok !== 3'b000 || lc_id_o !== '0)
            begin failures++; $display("FAIL mid_outputs got=busy%b done%b ok%b exp=0/000/000", busy, done, ok); end
        rst = 1'b1;
        @(posedge clk); #1;
        run_attempt(3'b111, 4, 1'b0, dc, dv, ov, rh, ida);
        checks++; if (dv !== 3'b001 || ov !== 3'b001)
            begin failures++; $display("FAIL mid_restart_idx0 got=%b/%b exp=001/001", dv, ov); end
        // Requester 1 was locked before reset; one failure now must not relock it.
        run_attempt(3'b010, -1, 1'b0, dc, dv, ov, rh, ida);
        checks++; if (dv !== 3'b010 || locked !== 3'b000)
            begin failures++; $display("FAIL mid_counter_cleared got=%b/%b exp=010/000", dv, locked); end
    endtask

    initial begin
        id0 = {8{32'hA5A5_0001}};
        id1 = {8{32'h5A5A_0002}};
        id2 = {8{32'h3C3C_0003}};
        req_id = {id2, id1, id0};
        test_reset();
        test_round_robin();
        test_pass();
        test_fail_lockout();
        test_locked_ignored();
        test_eol();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
